// File: rtl/mem_arbiter.sv
`default_nettype none

`ifndef MEM_ADDRESS_LEN
`define MEM_ADDRESS_LEN 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif

// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (fetch / data) sequencing controller in front of a
//               single-ported combinational main memory. Alternating-priority
//               arbitration, fixed LATENCY hold, single write strobe per store
//               and a one-cycle ready pulse per completed access.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = `MEM_ADDRESS_LEN,
    parameter int DATA_W  = `MEM_DATA_WIDTH,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wrt_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_ACCESS = 2'd1;
    localparam logic [1:0] C_DONE   = 2'd2;

    localparam logic C_GNT_IF = 1'b0;
    localparam logic C_GNT_DC = 1'b1;

    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(LATENCY - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_grant;
    logic              r_grant;
    logic              r_we;
    logic              r_busy;
    logic              r_if_ready;
    logic              r_dc_ready;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dc_rdata;

    logic w_start;
    logic w_grant_dc;
    logic w_last_cycle;

    // DC wins when it is the only requester, or on a tie when IF was granted last.
    assign w_grant_dc   = dc_req & (~if_req | (r_last_grant == C_GNT_IF));
    assign w_start      = (r_state == C_IDLE) & (if_req | dc_req);
    assign w_last_cycle = (r_state == C_ACCESS) & (r_cnt == '0);

    // Write strobe decoded from registered state only: one cycle per store.
    assign mem_wrt_en = w_last_cycle & (r_grant == C_GNT_DC) & r_we;

    assign if_ready  = r_if_ready;
    assign dc_ready  = r_dc_ready;
    assign if_rdata  = r_if_rdata;
    assign dc_rdata  = r_dc_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

    // Sequencing FSM: grant, latency countdown, ready pulse and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= C_IDLE;
            r_cnt        <= '0;
            r_last_grant <= C_GNT_IF;
            r_grant      <= C_GNT_IF;
            r_busy       <= 1'b0;
            r_if_ready   <= 1'b0;
            r_dc_ready   <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_start) begin
                        r_state      <= C_ACCESS;
                        r_cnt        <= C_CNT_INIT;
                        r_grant      <= w_grant_dc ? C_GNT_DC : C_GNT_IF;
                        r_last_grant <= w_grant_dc ? C_GNT_DC : C_GNT_IF;
                        r_busy       <= 1'b1;
                    end
                end
                C_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state    <= C_DONE;
                        r_if_ready <= (r_grant == C_GNT_IF);
                        r_dc_ready <= (r_grant == C_GNT_DC);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                C_DONE: begin
                    r_state    <= C_IDLE;
                    r_busy     <= 1'b0;
                    r_if_ready <= 1'b0;
                    r_dc_ready <= 1'b0;
                end
                default: begin
                    r_state    <= C_IDLE;
                    r_busy     <= 1'b0;
                    r_if_ready <= 1'b0;
                    r_dc_ready <= 1'b0;
                end
            endcase
        end
    end

    // Latch the winning request; values hold through ACCESS/DONE and linger in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_we        <= 1'b0;
        end else if (w_start) begin
            r_mem_addr <= w_grant_dc ? dc_addr : if_addr;
            r_we       <= w_grant_dc & dc_we;
            if (w_grant_dc) begin
                r_mem_wdata <= dc_wdata;
            end
        end
    end

    // Capture read data into the granted port's register on the final ACCESS cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_rdata <= '0;
            r_dc_rdata <= '0;
        end else if (w_last_cycle && !r_we) begin
            if (r_grant == C_GNT_IF) begin
                r_if_rdata <= mem_rdata;
            end else begin
                r_dc_rdata <= mem_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none

// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (LATENCY=5 and LATENCY=1)
//               with a small combinational memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    // LATENCY = 5 instance
    logic        if_req, dc_req, dc_we;
    logic [31:0] if_addr, dc_addr, dc_wdata;
    logic        if_ready, dc_ready, mem_wrt_en, busy;
    logic [31:0] if_rdata, dc_rdata, mem_addr, mem_wdata, mem_rdata;

    // LATENCY = 1 instance
    logic        if1_req, dc1_req, dc1_we;
    logic [31:0] if1_addr, dc1_addr, dc1_wdata;
    logic        if1_ready, dc1_ready, mem1_wrt_en, busy1;
    logic [31:0] if1_rdata, dc1_rdata, mem1_addr, mem1_wdata, mem1_rdata;

    // Memory model: 16 words selected by address bits [15:12]
    logic [31:0] mem [16];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign mem_rdata  = mem[mem_addr[15:12]];
    assign mem1_rdata = {mem1_addr[15:0], 16'h5A5A};

    // Memory write port: DUT strobe, or bench preload while the DUT is idle.
    always @(posedge clk) begin
        if (mem_wrt_en) mem[mem_addr[15:12]] <= mem_wdata;
        else if (pl_en) mem[pl_idx] <= pl_data;
    end

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(5)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wrt_en(mem_wrt_en),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if1_req), .if_addr(if1_addr), .if_ready(if1_ready), .if_rdata(if1_rdata),
        .dc_req(dc1_req), .dc_we(dc1_we), .dc_addr(dc1_addr), .dc_wdata(dc1_wdata),
        .dc_ready(dc1_ready), .dc_rdata(dc1_rdata),
        .mem_addr(mem1_addr), .mem_wdata(mem1_wdata), .mem_wrt_en(mem1_wrt_en),
        .mem_rdata(mem1_rdata), .busy(busy1)
    );

    typedef struct {
        logic        dc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;   // expected rdata of the requesting port afterwards
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b0;
    endtask

    // One transaction on the LATENCY=5 instance; n counts posedges since req set.
    task automatic run_txn(input vec_t v, input string tag);
        int n, rdy_n, wr_n;
        logic other;
        logic [31:0] addr_seen;
        @(posedge clk); #1;
        if (v.dc) begin
            dc_req = 1'b1; dc_we = v.we; dc_addr = v.addr; dc_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        n = 0; rdy_n = -1; wr_n = 0; other = 1'b0; addr_seen = '0;
        while (rdy_n < 0 && n < 40) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (mem_wrt_en) wr_n++;
            if (v.dc ? if_ready : dc_ready) other = 1'b1;
            if (v.dc ? dc_ready : if_ready) begin
                rdy_n = n; addr_seen = mem_addr;
                if_req = 1'b0; dc_req = 1'b0;
            end
        end
        check({tag, " latency"}, 32'(rdy_n), 32'd6);
        check({tag, " write strobes"}, 32'(wr_n), v.we ? 32'd1 : 32'd0);
        check({tag, " mem_addr"}, addr_seen, v.addr);
        check({tag, " other ready"}, 32'(other), 32'd0);
        @(posedge clk); @(negedge clk);
        check({tag, " ready width"}, 32'(v.dc ? dc_ready : if_ready), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " rdata"}, v.dc ? dc_rdata : if_rdata, v.exp_rdata);
    endtask

    // Both ports request together; completions expected DC, IF, DC, IF, 7 cycles apart.
    task automatic both_ports(input bit hold, input int want, input string tag);
        int n, evt;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h1000;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h3000;
        n = 0; evt = 0;
        while (n < 40) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (dc_ready || if_ready) begin
                check($sformatf("%s evt%0d port", tag, evt), 32'(dc_ready), (evt % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("%s evt%0d cycle", tag, evt), 32'(n), 32'(6 + 7 * evt));
                if (dc_ready) begin
                    check($sformatf("%s evt%0d dc_rdata", tag, evt), dc_rdata, 32'hCAFEF00D);
                    if (!hold) dc_req = 1'b0;
                end else begin
                    check($sformatf("%s evt%0d if_rdata", tag, evt), if_rdata, 32'h08010080);
                    if (!hold) if_req = 1'b0;
                end
                evt++;
                if (evt == want) begin
                    if_req = 1'b0; dc_req = 1'b0;
                end
            end
        end
        check({tag, " completions"}, 32'(evt), 32'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rdy, wr1;

        reset = 1'b1;
        if_req = 1'b0; if_addr = '0; dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
        if1_req = 1'b0; if1_addr = '0; dc1_req = 1'b0; dc1_we = 1'b0; dc1_addr = '0; dc1_wdata = '0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;

        for (int i = 0; i < 16; i++) preload(4'(i), 32'h0);
        preload(4'h1, 32'h08010080);
        preload(4'h4, 32'hAAAA5555);

        @(negedge clk);
        check("reset if_ready",   32'(if_ready),   32'd0);
        check("reset dc_ready",   32'(dc_ready),   32'd0);
        check("reset busy",       32'(busy),       32'd0);
        check("reset mem_wrt_en", 32'(mem_wrt_en), 32'd0);
        check("reset mem_addr",   mem_addr,        32'd0);
        check("reset mem_wdata",  mem_wdata,       32'd0);
        check("reset if_rdata",   if_rdata,        32'd0);
        check("reset dc_rdata",   dc_rdata,        32'd0);
        reset = 1'b0;

        vecs[0] = '{dc: 1'b0, we: 1'b0, addr: 32'h1000, wdata: 32'h0,        exp_rdata: 32'h08010080};
        vecs[1] = '{dc: 1'b1, we: 1'b1, addr: 32'h2000, wdata: 32'hDEADBEEF, exp_rdata: 32'h0};
        vecs[2] = '{dc: 1'b1, we: 1'b0, addr: 32'h2000, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
        vecs[3] = '{dc: 1'b0, we: 1'b0, addr: 32'h2000, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
        vecs[4] = '{dc: 1'b1, we: 1'b1, addr: 32'h3000, wdata: 32'hCAFEF00D, exp_rdata: 32'hDEADBEEF};
        vecs[5] = '{dc: 1'b1, we: 1'b0, addr: 32'h3000, wdata: 32'h0,        exp_rdata: 32'hCAFEF00D};

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // LATENCY=1 fetch
        @(posedge clk); #1;
        if1_req = 1'b1; if1_addr = 32'h7000;
        n = 0; rdy = -1; wr1 = 0;
        while (rdy < 0 && n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (mem1_wrt_en) wr1++;
            if (if1_ready) begin rdy = n; if1_req = 1'b0; end
        end
        check("lat1 latency", 32'(rdy), 32'd2);
        @(posedge clk); @(negedge clk);
        check("lat1 idle busy",   32'(busy1),     32'd0);
        check("lat1 ready width", 32'(if1_ready), 32'd0);
        check("lat1 rdata",       if1_rdata,      32'h70005A5A);
        check("lat1 strobes",     32'(wr1),       32'd0);

        pulse_reset();
        both_ports(1'b0, 2, "tie");

        pulse_reset();
        both_ports(1'b1, 4, "alt");

        // Reset asserted just after edge 3 of a store
        pulse_reset();
        @(posedge clk); #1;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h4000; dc_wdata = 32'h11112222;
        repeat (4) @(posedge clk);
        #1;
        check("abort pre busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort mem_wrt_en", 32'(mem_wrt_en), 32'd0);
        check("abort busy",       32'(busy),       32'd0);
        check("abort dc_ready",   32'(dc_ready),   32'd0);
        dc_req = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); reset = 1'b0;
        repeat (8) @(negedge clk);
        check("abort mem kept", mem[4], 32'hAAAA5555);
        check("abort no ready", 32'(dc_ready), 32'd0);
        run_txn('{dc: 1'b1, we: 1'b1, addr: 32'h4000, wdata: 32'h11112222, exp_rdata: 32'h0}, "reissue");
        check("reissue mem", mem[4], 32'h11112222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port sequencing controller in front of the single-ported, combinational `main_memory`. It arbitrates between the instruction-fetch port (`if_*`) and the data-cache/LSU port (`dc_*`) and holds a granted address for a fixed `LATENCY` cycles to model main-memory access time. It issues exactly one write strobe per store and returns read data with a one-cycle `ready` pulse. It sits between the core front end / memory stage and `main_memory`, and is the only driver of `main_memory`'s inputs.

## Interface
Parameters:
- `ADDR_W`, default `MEM_ADDRESS_LEN`: address width, passed through unchanged.
- `DATA_W`, default `MEM_DATA_WIDTH`: data word width.
- `LATENCY`, default 5: cycles a granted access occupies memory. Legal values are ≥ 1.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `if_req`, in, 1: fetch request. Held with `if_addr` until `if_ready`.
- `if_addr`, in, `ADDR_W`: fetch address.
- `if_ready`, out, 1: one-cycle completion pulse for fetch.
- `if_rdata`, out, `DATA_W`: fetched word. Valid from `if_ready` until the next fetch completes.
- `dc_req`, in, 1: data request. Held with `dc_we`/`dc_addr`/`dc_wdata` until `dc_ready`.
- `dc_we`, in, 1: 1 = store, 0 = load.
- `dc_addr`, in, `ADDR_W`: data address.
- `dc_wdata`, in, `DATA_W`: store data.
- `dc_ready`, out, 1: one-cycle completion pulse for data (load or store).
- `dc_rdata`, out, `DATA_W`: load result. Valid from `dc_ready` until the next data load completes. Unchanged by stores.
- `mem_addr`, out, `ADDR_W`: to `main_memory.addr`.
- `mem_wdata`, out, `DATA_W`: to `main_memory.data_to_write`.
- `mem_wrt_en`, out, 1: to `main_memory.wrt_en`.
- `mem_rdata`, in, `DATA_W`: from `main_memory.data_to_read`.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- FSM has three states.
  - **IDLE**: samples requests at each edge.
  - **ACCESS**: runs a down-counter `cnt` for `LATENCY` cycles.
  - **DONE**: asserts the `ready` pulse for exactly one cycle, then returns to IDLE.
- IDLE → ACCESS when `if_req | dc_req`. On that edge the controller latches:
  - the grant;
  - the winning port's address, and for a data grant also `we` and `wdata`;
  - `cnt = LATENCY-1`.
- Arbitration when only one port requests: that port wins.
- Arbitration when both request in the same IDLE cycle: the port not granted last wins.
  - `last_grant` is updated at each grant.
  - `last_grant` resets to IF, so the first tie goes to DC.
- ACCESS: `cnt` decrements each edge. When `cnt == 0`:
  - a read captures `mem_rdata` into the granted port's `rdata` register;
  - the state moves to DONE.
- `mem_wrt_en` is high only during the single ACCESS cycle with `cnt == 0` and a granted store. It is 0 in every other state and cycle, so each store performs one write.
- `mem_addr` and `mem_wdata` hold the latched values throughout ACCESS and DONE, and keep their last values in IDLE.
- DONE: the granted port's `ready` is 1. New requests are ignored in DONE. Next edge → IDLE.
- A requester that keeps `req` high after its `ready` is treated as issuing a new request.
- Requests from the non-granted port stay pending and are never dropped. They win at the next IDLE where they are the only requester or where the alternation rule favours them.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0, `last_grant` = IF;
  - `if_ready` = `dc_ready` = 0;
  - `mem_wrt_en` = 0, `busy` = 0;
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dc_rdata` = 0.
- Latency, taking the edge that samples `req` in IDLE as edge 0:
  - ACCESS spans edges 1..`LATENCY`;
  - `ready` is high in the cycle after edge `LATENCY`;
  - the controller is back in IDLE after edge `LATENCY+1`.
- Occupancy and throughput:
  - one transaction occupies `LATENCY+2` cycles;
  - maximum throughput is one access per `LATENCY+2` cycles.
- `LATENCY=1`: ACCESS lasts one cycle, with `cnt == 0` on entry.
- Reset asserted mid-ACCESS (asynchronous):
  - immediate return to IDLE;
  - `mem_wrt_en` drops immediately and the in-flight store is not written;
  - no `ready` is issued for the aborted access.
- `ready` outputs and `busy` are registered. `mem_wrt_en` is decoded from registered state only.

## Test plan
- Single fetch, `LATENCY=5`, `if_addr=0x1000`, memory model returns 0x08010080:
  - `if_ready` high exactly one cycle, after edge 5;
  - `if_rdata` = 0x08010080;
  - `mem_wrt_en` never high.
- Store then load, `dc_we=1`, `dc_addr=0x2000`, `dc_wdata=0xDEADBEEF`:
  - exactly one `mem_wrt_en` cycle (the `cnt == 0` cycle);
  - `dc_ready` after edge 5;
  - the following load from 0x2000 gives `dc_rdata` = 0xDEADBEEF.
- Simultaneous `if_req`/`dc_req` right after reset:
  - DC granted first (`dc_ready` at cycle 6);
  - IF granted next (`if_ready` 7 cycles later).
- Both ports held requesting for 4 transactions:
  - grants alternate DC, IF, DC, IF;
  - each completion is spaced 7 cycles apart.
- Reset asserted at edge 3 of a store:
  - `mem_wrt_en`, `busy` and `dc_ready` go 0 immediately;
  - memory contents are unchanged;
  - a re-issued store completes normally.
- `LATENCY=1` fetch: `if_ready` high in the cycle after edge 1, and the controller is in IDLE after edge 2.
